// File: rtl/keccak_pkg.sv
// Shared Keccak constants, rho offset table and rho lane unit state encoding.
package keccak_pkg;

  localparam int KECCAK_W     = 64;
  localparam int KECCAK_LANES = 25;
  localparam int KECCAK_ZW    = $clog2(KECCAK_W);

  // Entry i is the rho offset of lane i (x+5y); lane 24 is the leftmost entry.
  localparam logic [KECCAK_LANES-1:0][KECCAK_ZW-1:0] RHO_OFFSET = {
    6'd14, 6'd56, 6'd61, 6'd2,  6'd18, 6'd8,  6'd21, 6'd15, 6'd45,
    6'd41, 6'd39, 6'd25, 6'd43, 6'd10, 6'd3,  6'd20, 6'd55, 6'd6,
    6'd44, 6'd36, 6'd27, 6'd28, 6'd62, 6'd1,  6'd0
  };

  typedef enum logic [2:0] {
    RHO_IDLE,
    RHO_GATHER,
    RHO_SC_RD,
    RHO_SC_WR,
    RHO_DONE
  } rho_state_e;

endpackage

// File: rtl/keccak_rho_lane_unit_if.sv
// Start/done handshake plus slice-memory port between the step sequencer and the rho lane unit.
interface keccak_rho_lane_unit_if;
  import keccak_pkg::*;

  logic                      start;
  logic [4:0]                lane_idx;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic [KECCAK_ZW-1:0]      mem_addr;
  logic                      mem_rd;
  logic [KECCAK_LANES-1:0]   mem_rdata;
  logic                      mem_wr;
  logic [KECCAK_LANES-1:0]   mem_wdata;

  modport master (
    output start, lane_idx, mem_rdata,
    input  busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    input  start, lane_idx, mem_rdata,
    output busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
  );

endinterface

// File: rtl/keccak_rho_offset_rom.sv
// Combinational lane index -> rho offset lookup; out-of-range lanes map to 0.
module keccak_rho_offset_rom
  import keccak_pkg::*;
(
  input  logic [4:0]           lane_idx_i,
  output logic [KECCAK_ZW-1:0] offset_o
);

  always_comb begin
    offset_o = '0;
    if (lane_idx_i < 5'(KECCAK_LANES)) begin
      offset_o = RHO_OFFSET[lane_idx_i];
    end
  end

endmodule

// File: rtl/keccak_rho_lane_unit.sv
// Rho-rotates one lane of the slice-organised state: bit-serial gather of all 64 slices,
// then a read-modify-write pass that replaces only that lane's bit in each slice.
module keccak_rho_lane_unit
  import keccak_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  keccak_rho_lane_unit_if.slave bus
);

  rho_state_e            state_q;
  logic [4:0]            lane_q;
  logic [KECCAK_ZW-1:0]  rhoOff_q;
  logic [KECCAK_W-1:0]   laneBuf_q;
  logic [KECCAK_ZW:0]    z_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  memRd_q;
  logic                  memWr_q;
  logic [KECCAK_ZW-1:0]  memAddr_q;

  logic [KECCAK_ZW-1:0]  romOffset;
  logic [KECCAK_ZW-1:0]  captIdx;
  logic [KECCAK_ZW-1:0]  srcIdx;

  keccak_rho_offset_rom u_rom (
    .lane_idx_i (bus.lane_idx),
    .offset_o   (romOffset)
  );

  // During gather z_q runs one ahead of the slice being captured (read latency of one).
  assign captIdx = KECCAK_ZW'(z_q - 1'b1);
  assign srcIdx  = z_q[KECCAK_ZW-1:0] - rhoOff_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RHO_IDLE;
      lane_q    <= '0;
      rhoOff_q  <= '0;
      laneBuf_q <= '0;
      z_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      memRd_q   <= 1'b0;
      memWr_q   <= 1'b0;
      memAddr_q <= '0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      memRd_q <= 1'b0;
      memWr_q <= 1'b0;
      unique case (state_q)
        RHO_IDLE: begin
          if (bus.start) begin
            lane_q   <= bus.lane_idx;
            rhoOff_q <= romOffset;
            z_q      <= '0;
            if (bus.lane_idx >= 5'(KECCAK_LANES)) begin
              state_q <= RHO_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (romOffset == '0) begin
              state_q <= RHO_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= RHO_GATHER;
              busy_q    <= 1'b1;
              memRd_q   <= 1'b1;
              memAddr_q <= '0;
            end
          end
        end
        RHO_GATHER: begin
          if (z_q != '0) begin
            laneBuf_q[captIdx] <= bus.mem_rdata[lane_q];
          end
          if (z_q == (KECCAK_ZW+1)'(KECCAK_W)) begin
            state_q   <= RHO_SC_RD;
            z_q       <= '0;
            memRd_q   <= 1'b1;
            memAddr_q <= '0;
          end else begin
            z_q <= z_q + 1'b1;
            if (z_q < (KECCAK_ZW+1)'(KECCAK_W - 1)) begin
              memRd_q   <= 1'b1;
              memAddr_q <= KECCAK_ZW'(z_q + 1'b1);
            end
          end
        end
        RHO_SC_RD: begin
          state_q <= RHO_SC_WR;
          memWr_q <= 1'b1;
        end
        RHO_SC_WR: begin
          if (z_q[KECCAK_ZW-1:0] == KECCAK_ZW'(KECCAK_W - 1)) begin
            state_q   <= RHO_DONE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            z_q       <= '0;
            memAddr_q <= '0;
          end else begin
            state_q   <= RHO_SC_RD;
            z_q       <= z_q + 1'b1;
            memRd_q   <= 1'b1;
            memAddr_q <= KECCAK_ZW'(z_q + 1'b1);
          end
        end
        RHO_DONE: begin
          state_q <= RHO_IDLE;
        end
        default: begin
          state_q <= RHO_IDLE;
        end
      endcase
    end
  end

  // Write data is the slice just read, with only this lane's bit swapped for the rotated one.
  always_comb begin
    bus.mem_wdata = '0;
    if (memWr_q) begin
      bus.mem_wdata         = bus.mem_rdata;
      bus.mem_wdata[lane_q] = laneBuf_q[srcIdx];
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.mem_rd   = memRd_q;
  assign bus.mem_wr   = memWr_q;
  assign bus.mem_addr = memAddr_q;

endmodule

// File: tb/tb_keccak_rho_lane_unit.sv
// Bench for keccak_rho_lane_unit: slice memory model, lane-rotation reference model,
// vector table for single-lane cases plus hand-written back-to-back, restart and reset sequences.
module tb_keccak_rho_lane_unit;

  typedef struct {
    int lane;
    int seedSlice;
    int expSlice;
    int expDone;
    int expErr;
    int expWr;
    int expRd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keccak_rho_lane_unit_if bus();

  keccak_rho_lane_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [4:0] romLane;
  logic [5:0] romOff;
  keccak_rho_offset_rom romChk (
    .lane_idx_i (romLane),
    .offset_o   (romOff)
  );

  int rhoTab [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                      41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  logic [24:0] mem    [64];
  logic [24:0] img    [64];
  logic [24:0] refMem [64];
  logic        loadEn = 1'b0;

  int wrCount = 0, rdCount = 0, doneCount = 0, errCount = 0, overlapCount = 0;
  int nCompared = 0, nMismatched = 0;

  // Slice memory: one-cycle registered read, write on strobe, bulk load from img.
  always @(posedge clk) begin
    if (loadEn) begin
      for (int z = 0; z < 64; z++) mem[z] <= img[z];
    end else if (bus.mem_wr) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (bus.mem_wr) wrCount++;
    if (bus.mem_rd) rdCount++;
    if (bus.done) doneCount++;
    if (bus.err) errCount++;
    if (bus.mem_rd && bus.mem_wr) overlapCount++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
    if (r == 0) return x;
    return (x << r) | (x >> (64 - r));
  endfunction

  function automatic logic [63:0] refLaneRotated(input int lane);
    logic [63:0] bits;
    for (int z = 0; z < 64; z++) bits[z] = refMem[z][lane];
    return rotl(bits, rhoTab[lane]);
  endfunction

  task automatic refApply(input int lane);
    logic [63:0] rot;
    if (lane < 25) begin
      rot = refLaneRotated(lane);
      for (int z = 0; z < 64; z++) refMem[z][lane] = rot[z];
    end
  endtask

  task automatic loadMem();
    @(negedge clk) loadEn = 1'b1;
    @(negedge clk) loadEn = 1'b0;
    for (int z = 0; z < 64; z++) refMem[z] = img[z];
  endtask

  task automatic initMem(input int lane, input int seedSlice);
    for (int z = 0; z < 64; z++) begin
      img[z] = 25'($urandom);
      if (lane < 25) img[z][lane] = 1'b0;
    end
    if (lane < 25 && seedSlice >= 0) img[seedSlice][lane] = 1'b1;
    loadMem();
  endtask

  task automatic compareMem(input string tag);
    for (int z = 0; z < 64; z++)
      checkOutput($sformatf("%s slice%0d", tag, z), 64'(mem[z]), 64'(refMem[z]));
  endtask

  // Issues start in the next cycle; cycle 1 is the first cycle after the start edge.
  task automatic applyStimulus(input int lane, input int pulseA, input int pulseB,
                               output int doneCyc, output int errSeen, output int busyAt1);
    int cyc;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.lane_idx = 5'(lane);
    cyc     = 0;
    doneCyc = -1;
    errSeen = 0;
    busyAt1 = 0;
    while (doneCyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busyAt1 = int'(bus.busy);
      if (bus.done) begin
        doneCyc = cyc;
        errSeen = int'(bus.err);
      end
      bus.start    = (cyc == pulseA || cyc == pulseB);
      bus.lane_idx = bus.start ? 5'd1 : 5'(lane);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    vec_t vecs [5];
    int doneCyc, errSeen, busyAt1, wr0, rd0, dn0, er0;
    logic [63:0] rot;

    vecs[0] = '{lane: 1,  seedSlice: 0,  expSlice: 1,  expDone: 194, expErr: 0, expWr: 64, expRd: 128};
    vecs[1] = '{lane: 2,  seedSlice: 5,  expSlice: 3,  expDone: 194, expErr: 0, expWr: 64, expRd: 128};
    vecs[2] = '{lane: 10, seedSlice: 62, expSlice: 1,  expDone: 194, expErr: 0, expWr: 64, expRd: 128};
    vecs[3] = '{lane: 0,  seedSlice: 7,  expSlice: 7,  expDone: 1,   expErr: 0, expWr: 0,  expRd: 0};
    vecs[4] = '{lane: 27, seedSlice: -1, expSlice: -1, expDone: 1,   expErr: 1, expWr: 0,  expRd: 0};

    bus.start    = 1'b0;
    bus.lane_idx = 5'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy/done/err", {bus.busy, bus.done, bus.err}, 3'b000);
    checkOutput("reset rd/wr", {bus.mem_rd, bus.mem_wr}, 2'b00);
    checkOutput("reset addr", bus.mem_addr, 0);
    checkOutput("reset wdata", bus.mem_wdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      romLane = 5'(i);
      #1;
      checkOutput($sformatf("rom lane%0d", i), romOff, (i < 25) ? rhoTab[i] : 0);
    end

    for (int v = 0; v < 5; v++) begin
      initMem(vecs[v].lane, vecs[v].seedSlice);
      refApply(vecs[v].lane);
      wr0 = wrCount; rd0 = rdCount;
      applyStimulus(vecs[v].lane, -1, -1, doneCyc, errSeen, busyAt1);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("v%0d done cycle", v), doneCyc, vecs[v].expDone);
      checkOutput($sformatf("v%0d err", v), errSeen, vecs[v].expErr);
      checkOutput($sformatf("v%0d busy@1", v), busyAt1, (vecs[v].expDone > 1) ? 1 : 0);
      checkOutput($sformatf("v%0d writes", v), wrCount - wr0, vecs[v].expWr);
      checkOutput($sformatf("v%0d reads", v), rdCount - rd0, vecs[v].expRd);
      if (vecs[v].expSlice >= 0)
        checkOutput($sformatf("v%0d target bit", v), mem[vecs[v].expSlice][vecs[v].lane], 1);
      compareMem($sformatf("v%0d", v));
    end

    // All rotating lanes back to back over one random state.
    initMem(25, -1);
    er0 = errCount;
    for (int l = 1; l < 25; l++) begin
      refApply(l);
      applyStimulus(l, -1, -1, doneCyc, errSeen, busyAt1);
      checkOutput($sformatf("b2b lane%0d done cycle", l), doneCyc, 194);
    end
    repeat (2) @(negedge clk);
    checkOutput("b2b err count", errCount - er0, 0);
    compareMem("b2b");

    // Start pulses while busy must be ignored.
    initMem(25, -1);
    refApply(6);
    dn0 = doneCount;
    applyStimulus(6, 10, 100, doneCyc, errSeen, busyAt1);
    repeat (5) @(negedge clk);
    checkOutput("restart done cycle", doneCyc, 194);
    checkOutput("restart done count", doneCount - dn0, 1);
    compareMem("restart");

    // Reset at cycle 120 of a lane-3 rotation: slices 0..26 written, rest untouched.
    initMem(25, -1);
    rot = refLaneRotated(3);
    wr0 = wrCount;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.lane_idx = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (118) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst busy/done/err", {bus.busy, bus.done, bus.err}, 3'b000);
    checkOutput("midrst rd/wr", {bus.mem_rd, bus.mem_wr}, 2'b00);
    checkOutput("midrst addr", bus.mem_addr, 0);
    checkOutput("midrst writes before", wrCount - wr0, 27);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midrst writes after", wrCount - wr0, 27);
    for (int z = 0; z < 27; z++) refMem[z][3] = rot[z];
    compareMem("midrst");

    refApply(3);
    applyStimulus(3, -1, -1, doneCyc, errSeen, busyAt1);
    repeat (2) @(negedge clk);
    checkOutput("postrst done cycle", doneCyc, 194);
    compareMem("postrst");

    checkOutput("rd/wr overlap", overlapCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/keccak_rho_lane_unit.md
Name: keccak_rho_lane_unit

Overview:
- Responder for the Keccak step sequencer's rotate phase.
- On a start pulse it rho-rotates one 64-bit lane of the slice-organised state memory (64 slices x 25 bits, slice address = z, bit index = x+5y) by that lane's fixed rho offset.
- It reads the lane bit-serially across all slices, then read-modify-writes it back, and reports completion with a done pulse (the sequencer's finishLane).

Parameters:
- W, 64, lane length / number of slices (fixed at 64; the address width of 6 is derived from it).
- LANES, 25, lanes per slice (slice data width).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request pulse; lane_idx sampled with it
- lane_idx  in  5  lane to rotate (x+5y, valid 0..24)
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done when lane_idx > 24
- mem_addr  out  6  slice address z
- mem_rd  out  1  read strobe; data is valid on mem_rdata the next cycle
- mem_rdata  in  25  slice read data
- mem_wr  out  1  write strobe, one cycle
- mem_wdata  out  25  slice write data

Behaviour:
- Reset: all outputs 0; state IDLE; internal lane buffer, z counter and offset cleared.
- Reset mid-operation returns to IDLE immediately. The partial write-back is not undone, and no further writes occur.
- Offset table, r(lane): 0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14 for lanes 0..24.
- Rotation rule: new bit z = old bit ((z - r) mod 64). The subtraction is 6-bit and wraps naturally.
- IDLE:
  - start=1 latches lane_idx and r.
  - lane_idx > 24 -> DONE with err=1.
  - r == 0 (lane 0) -> DONE directly, with no memory access.
  - Otherwise -> GATHER.
  - start while not in IDLE is ignored.
- GATHER: pipelined read with z = 0..63 over 65 cycles.
  - Cycles 1..64 after the start edge: mem_rd=1, mem_addr=z.
  - Cycles 2..65: buf[z-1] <= mem_rdata[lane_idx].
  - After the capture of z=63 -> SC_RD with z=0.
- SC_RD: mem_rd=1, mem_addr=z -> SC_WR.
- SC_WR:
  - mem_wdata = mem_rdata with bit lane_idx replaced by buf[(z - r) mod 64].
  - mem_wr=1, mem_addr=z.
  - z==63 -> DONE; otherwise z+1 -> SC_RD.
- DONE: done=1 for exactly one cycle (err as decided in IDLE); busy=0; -> IDLE. A new start is accepted the next cycle.
- Latency for lanes 1..24: done is high in cycle 194 after the start edge (1 + 65 + 128).
- Latency for lane 0 or an invalid lane: done in cycle 1.
- Only bit lane_idx of each slice changes; the other 24 bits are written back unchanged.
- mem_rd and mem_wr are never high in the same cycle.

Decomposition:
- Shared package keccak_pkg:
  - constants KECCAK_W=64 and KECCAK_LANES=25;
  - RHO_OFFSET table, 25 entries x 6 bits;
  - state encoding for this unit.
- One natural sub-module: keccak_rho_offset_rom, a combinational lane_idx -> r lookup that the sequencer's tests can also reuse.
- The 64-bit lane buffer and the z counter stay inline.

Test Plan:
- Lane 1 (r=1): memory with only slice 0 bit 1 set.
  - After done: only slice 1 bit 1 set.
  - done in cycle 194; 64 writes observed.
- Lane 2 (r=62) wrap: slice 5 bit 2 set -> slice 3 bit 2 set (5+62 mod 64). All other bits of every slice unchanged.
- Lane 0 and lane_idx=27:
  - done in cycle 1 with no mem_rd/mem_wr;
  - err=0 for lane 0, err=1 for lane 27.
- Random 64x25 memory, all lanes 1..24 issued back to back (start the cycle after each done):
  - final memory matches the reference rho model;
  - err never asserted.
- start pulsed again at cycles 10 and 100 of a lane-6 operation: ignored; single done at 194; result correct for lane 6.
- rst asserted at cycle 120 of a lane-3 operation:
  - outputs 0 immediately; no further writes;
  - slices 0..26 already rewritten, slices 27..63 untouched;
  - a subsequent start completes normally.
